// File: rtl/core_sequencer_pkg.sv
// core_sequencer_pkg
// Shared definitions for the TinyRisc-V control sequencer:
//   - seq_state_e : 3-bit FSM state encoding
//   - OP_*        : major opcode constants the sequencer reacts to
//   - F3_*        : load/store func3 width codes
//   - width_legal : whether a func3 names a real load/store width
package core_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_EXEC  = 3'd2,
    ST_MEM   = 3'd3,
    ST_WB    = 3'd4,
    ST_HALT  = 3'd5,
    ST_FAULT = 3'd6
  } seq_state_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_BYTE  = 3'd0;
  localparam logic [2:0] F3_HALF  = 3'd1;
  localparam logic [2:0] F3_WORD  = 3'd2;
  localparam logic [2:0] F3_BYTEU = 3'd4;
  localparam logic [2:0] F3_HALFU = 3'd5;

  // Stores only exist as SB/SH/SW; loads add the unsigned byte/half forms.
  function automatic logic width_legal(input logic is_store, input logic [2:0] f3);
    if (is_store) begin
      width_legal = (f3 == F3_BYTE) || (f3 == F3_HALF) || (f3 == F3_WORD);
    end else begin
      width_legal = (f3 == F3_BYTE) || (f3 == F3_HALF) || (f3 == F3_WORD) ||
                    (f3 == F3_BYTEU) || (f3 == F3_HALFU);
    end
  endfunction

endpackage

// File: rtl/core_sequencer_if.sv
// core_sequencer_if
// Instruction- and data-memory handshake bundle.
//   imem_req/imem_addr  -> memory, imem_ack/imem_rdata <- memory
//   dmem_req/we/addr/wdata/wstrb -> memory, dmem_ack/dmem_rdata <- memory
// Modports: master (sequencer side), slave (memory side).
interface core_sequencer_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_wstrb;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;

  modport master (
    output imem_req, imem_addr,
    input  imem_ack, imem_rdata,
    output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
    input  dmem_ack, dmem_rdata
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_ack, imem_rdata,
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
    output dmem_ack, dmem_rdata
  );
endinterface

// File: rtl/core_sequencer_lsu_align.sv
// core_sequencer_lsu_align
// Combinational load/store lane logic.
//   is_store, func3, ea_lo : access kind, width code, low address bits
//   store_data             : rs2 value to be written
//   load_word              : aligned 32-bit word returned by memory
//   wdata, wstrb           : store data replicated onto lanes, byte enables
//   load_result            : extracted and sign/zero-extended load value
//   access_fault           : illegal width or misaligned address
module core_sequencer_lsu_align
  import core_sequencer_pkg::*;
(
  input  logic        is_store,
  input  logic [2:0]  func3,
  input  logic [1:0]  ea_lo,
  input  logic [31:0] store_data,
  input  logic [31:0] load_word,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic [31:0] load_result,
  output logic        access_fault
);

  logic       misalign;
  logic [7:0] byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    misalign = 1'b0;
    case (func3[1:0])
      2'd1:    misalign = ea_lo[0];
      2'd2:    misalign = (ea_lo != 2'b00);
      default: misalign = 1'b0;
    endcase
    access_fault = misalign || !width_legal(is_store, func3);
  end

  // Store data is replicated across every lane so memory only needs wstrb.
  always_comb begin
    wdata = store_data;
    wstrb = 4'b1111;
    case (func3[1:0])
      2'd0: begin
        wdata = {4{store_data[7:0]}};
        wstrb = 4'b0001 << ea_lo;
      end
      2'd1: begin
        wdata = {2{store_data[15:0]}};
        wstrb = ea_lo[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        wdata = store_data;
        wstrb = 4'b1111;
      end
    endcase
  end

  always_comb begin
    byte_sel = load_word[7:0];
    case (ea_lo)
      2'd0: byte_sel = load_word[7:0];
      2'd1: byte_sel = load_word[15:8];
      2'd2: byte_sel = load_word[23:16];
      2'd3: byte_sel = load_word[31:24];
      default: byte_sel = load_word[7:0];
    endcase
    half_sel = ea_lo[1] ? load_word[31:16] : load_word[15:0];

    load_result = load_word;
    case (func3)
      F3_BYTE:  load_result = {{24{byte_sel[7]}}, byte_sel};
      F3_BYTEU: load_result = {24'd0, byte_sel};
      F3_HALF:  load_result = {{16{half_sel[15]}}, half_sel};
      F3_HALFU: load_result = {16'd0, half_sel};
      default:  load_result = load_word;
    endcase
  end

endmodule

// File: rtl/core_sequencer.sv
// core_sequencer
// Multi-cycle control FSM of the TinyRisc-V core. Owns PC/IR, sequences
// FETCH -> EXEC -> (MEM) -> WB and counts retired instructions.
//   clk, rst_n      : clock, asynchronous active-low reset
//   enable          : allows leaving IDLE / continuing after WB
//   mem             : imem/dmem handshake bundle (master side)
//   ir, pc          : registered instruction and PC to decode_execute
//   opcode..redirect_pc : combinational results from decode_execute
//   rf_we/waddr/wdata   : register-file write port (pulses in WB)
//   halted, fault   : terminal-state indicators
//   instret         : retired-instruction counter
module core_sequencer
  import core_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          XLEN     = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            enable,
  core_sequencer_if.master mem,
  output logic [XLEN-1:0] ir,
  output logic [XLEN-1:0] pc,
  input  logic [6:0]      opcode,
  input  logic [2:0]      func3,
  input  logic            wb_reg,
  input  logic [4:0]      rd_num,
  input  logic [XLEN-1:0] rd_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            rf_we,
  output logic [4:0]      rf_waddr,
  output logic [XLEN-1:0] rf_wdata,
  output logic            halted,
  output logic            fault,
  output logic [XLEN-1:0] instret
);

  seq_state_e state_reg, state_next;

  logic [XLEN-1:0] pc_reg, ir_reg, instret_reg;
  logic [XLEN-1:0] ea_reg, rs2_reg, load_data_reg;
  logic [XLEN-1:1] redirect_pc_reg;
  logic [4:0]      rd_num_reg;
  logic [2:0]      func3_reg;
  logic [6:0]      opcode_reg;
  logic            wb_en_reg, redirect_reg;

  // The LSU sees the live decode results in EXEC (for the fault decision)
  // and the latched copies afterwards (for the actual access).
  logic        lsu_is_store;
  logic [2:0]  lsu_func3;
  logic [1:0]  lsu_ea_lo;
  logic [31:0] lsu_wdata;
  logic [3:0]  lsu_wstrb;
  logic [31:0] lsu_load_result;
  logic        lsu_fault;
  logic        exec_is_mem;
  logic        store_reg_kind;

  assign exec_is_mem    = (opcode == OP_LOAD) || (opcode == OP_STORE);
  assign store_reg_kind = (opcode_reg == OP_STORE);
  assign lsu_is_store   = (state_reg == ST_EXEC) ? (opcode == OP_STORE) : store_reg_kind;
  assign lsu_func3      = (state_reg == ST_EXEC) ? func3 : func3_reg;
  assign lsu_ea_lo      = (state_reg == ST_EXEC) ? rd_data[1:0] : ea_reg[1:0];

  core_sequencer_lsu_align u_lsu (
    .is_store     (lsu_is_store),
    .func3        (lsu_func3),
    .ea_lo        (lsu_ea_lo),
    .store_data   (rs2_reg),
    .load_word    (mem.dmem_rdata),
    .wdata        (lsu_wdata),
    .wstrb        (lsu_wstrb),
    .load_result  (lsu_load_result),
    .access_fault (lsu_fault)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (enable) state_next = ST_FETCH;
      ST_FETCH: if (mem.imem_ack) state_next = ST_EXEC;
      ST_EXEC: begin
        if (opcode == OP_SYSTEM) begin
          state_next = ST_HALT;
        end else if (exec_is_mem) begin
          state_next = lsu_fault ? ST_FAULT : ST_MEM;
        end else begin
          state_next = ST_WB;
        end
      end
      ST_MEM:   if (mem.dmem_ack) state_next = ST_WB;
      ST_WB:    state_next = enable ? ST_FETCH : ST_IDLE;
      ST_HALT:  state_next = ST_HALT;
      ST_FAULT: state_next = ST_FAULT;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_reg          <= RESET_PC;
      ir_reg          <= '0;
      instret_reg     <= '0;
      ea_reg          <= '0;
      rs2_reg         <= '0;
      load_data_reg   <= '0;
      redirect_pc_reg <= '0;
      rd_num_reg      <= '0;
      func3_reg       <= '0;
      opcode_reg      <= '0;
      wb_en_reg       <= 1'b0;
      redirect_reg    <= 1'b0;
    end else begin
      case (state_reg)
        ST_FETCH: begin
          if (mem.imem_ack) ir_reg <= mem.imem_rdata;
        end
        ST_EXEC: begin
          ea_reg          <= rd_data;
          rs2_reg         <= rs2_data;
          rd_num_reg      <= rd_num;
          wb_en_reg       <= wb_reg;
          func3_reg       <= func3;
          opcode_reg      <= opcode;
          redirect_reg    <= redirect;
          redirect_pc_reg <= redirect_pc[XLEN-1:1];
          // SYSTEM retires here because it never reaches WB.
          if (opcode == OP_SYSTEM) instret_reg <= instret_reg + 1'b1;
        end
        ST_MEM: begin
          if (mem.dmem_ack && !store_reg_kind) load_data_reg <= lsu_load_result;
        end
        ST_WB: begin
          pc_reg      <= redirect_reg ? {redirect_pc_reg, 1'b0} : pc_reg + 32'd4;
          instret_reg <= instret_reg + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Outputs
  always_comb begin
    mem.imem_req   = 1'b0;
    mem.imem_addr  = pc_reg;
    mem.dmem_req   = 1'b0;
    mem.dmem_we    = 1'b0;
    mem.dmem_addr  = '0;
    mem.dmem_wdata = '0;
    mem.dmem_wstrb = '0;
    rf_we          = 1'b0;
    rf_waddr       = '0;
    rf_wdata       = '0;
    halted         = 1'b0;
    fault          = 1'b0;
    case (state_reg)
      ST_FETCH: mem.imem_req = 1'b1;
      ST_MEM: begin
        mem.dmem_req  = 1'b1;
        mem.dmem_we   = store_reg_kind;
        mem.dmem_addr = {ea_reg[XLEN-1:2], 2'b00};
        if (store_reg_kind) begin
          mem.dmem_wdata = lsu_wdata;
          mem.dmem_wstrb = lsu_wstrb;
        end
      end
      ST_WB: begin
        rf_we    = wb_en_reg && (rd_num_reg != 5'd0);
        rf_waddr = rd_num_reg;
        rf_wdata = (opcode_reg == OP_LOAD) ? load_data_reg : ea_reg;
      end
      ST_HALT:  halted = 1'b1;
      ST_FAULT: begin
        halted = 1'b1;
        fault  = 1'b1;
      end
      default: ;
    endcase
  end

  assign ir      = ir_reg;
  assign pc      = pc_reg;
  assign instret = instret_reg;

endmodule

// File: doc/core_sequencer.md
Name: core_sequencer

Overview:
Multi-cycle control FSM for the TinyRisc-V core. It owns the PC and IR registers and drives the combinational decode_execute datapath with ir/pc. It sequences instruction fetch, data memory access and register writeback over valid/ack handshakes. It retires one instruction per FETCH→EXEC→(MEM)→WB pass and counts retired instructions.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset
XLEN, 32, datapath width (only 32 supported)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  async active-low reset
enable  in  1  permits leaving IDLE
imem_req  out  1  fetch request, held until ack
imem_addr  out  32  = pc
imem_ack  in  1  fetch data valid this cycle
imem_rdata  in  32  instruction word
ir  out  32  to decode_execute
pc  out  32  to decode_execute
opcode  in  7  from decode_execute
func3  in  3  from decode_execute
wb_reg  in  1  instruction writes rd
rd_num  in  5  destination register
rd_data  in  32  ALU result / effective address
rs2_data  in  32  store data
redirect  in  1  taken branch or jump
redirect_pc  in  32  target when redirect=1
dmem_req  out  1  data request, held until ack
dmem_we  out  1  1=store
dmem_addr  out  32  {ea[31:2],2'b00}
dmem_wdata  out  32  store data shifted to lane
dmem_wstrb  out  4  byte enables
dmem_ack  in  1  data access complete / rdata valid
dmem_rdata  in  32  aligned load word
rf_we  out  1  regfile write enable
rf_waddr  out  5  regfile write index
rf_wdata  out  32  regfile write data
halted  out  1  in HALT or FAULT
fault  out  1  in FAULT
instret  out  32  retired-instruction count

Behaviour:
- Reset (async, rst_n=0): state=IDLE, pc=RESET_PC, ir=0, instret=0; all request/enable outputs 0, data outputs 0.
- States: IDLE, FETCH, EXEC, MEM, WB, HALT, FAULT.
- IDLE: enable=1 → FETCH next cycle.
- FETCH: imem_req=1, imem_addr=pc stable. imem_ack=1 → ir<=imem_rdata, go EXEC. Ack on the same cycle as req entry is legal (1-cycle fetch minimum).
- EXEC: single cycle; datapath combinational from registered ir. Latch rd_data→ea, rs2_data, rd_num, wb_reg, func3, opcode, redirect, redirect_pc.
  - opcode 1110011 (SYSTEM) → HALT; instret is incremented.
  - LOAD (0000011)/STORE (0100011) → alignment check; misaligned or load func3∈{3,6,7} or store func3>2 → FAULT; otherwise MEM.
  - Else → WB.
- Alignment: half requires ea[0]=0; word requires ea[1:0]=00.
- MEM: dmem_req=1 with stable addr/we/wdata/wstrb until dmem_ack. Store: SB wstrb=1<<ea[1:0], wdata=rs2[7:0] replicated ×4; SH wstrb=0011/1100 by ea[1], wdata=rs2[15:0] ×2; SW 1111. Load on ack: extract byte/half by ea[1:0], sign-extend (LB/LH) or zero-extend (LBU/LHU); register the result. Then WB.
- WB (one cycle): rf_we=wb_reg && rd_num!=0; wdata=load result for LOAD else latched rd_data. pc<=redirect ? {redirect_pc[31:1],1'b0} : pc+4 (wraps mod 2^32). instret+=1 (wraps). → FETCH, or IDLE if enable=0.
- HALT/FAULT: terminal until reset. pc holds the faulting/halting instruction address. No memory requests, no rf write.
- Ack while the corresponding req=0 is ignored, including stale acks after reset.
- Reset mid-handshake drops req immediately (async).
- rf_we is a one-cycle pulse only in WB; imem_req and dmem_req are never both high.

Decomposition:
- Shared header param_seq_state.vh: state encodings (3-bit), opcode constants (OP_LOAD, OP_STORE, OP_SYSTEM, OP_BRANCH), func3 width-code constants.
- One sub-module: lsu_align (combinational): store lane/strobe generation, load extract/extend, misalign detect.

Test Plan:
- ADDI x1,x0,5 (rd_data=5, wb_reg=1), imem_ack delayed 3 cycles → imem_req held 3 cycles; WB: rf_we=1, waddr=1, wdata=5; pc 0→4; instret=1.
- Taken branch: redirect=1, redirect_pc=0x40 → rf_we=0, next imem_addr=0x40; odd target 0x41 → 0x40.
- LB at ea=0x103, dmem_rdata=0x80_00_00_00 → dmem_addr=0x100, wdata=0xFFFFFF80; LBU gives 0x00000080.
- SH at ea=0x202, rs2=0x1234ABCD → wstrb=1100, wdata=0xABCDABCD, we=1; dmem_ack after 2 cycles; no rf write.
- LW at ea=0x101 → FAULT, fault=halted=1, dmem_req never asserted, pc unchanged.
- ECALL → HALT, instret increments, no further imem_req; rst_n pulse during FETCH → imem_req=0 immediately, pc=RESET_PC.
